// File: rtl/imem_line_server.sv
// Purpose: serves 128-bit cache refill lines from a 1024x32 word store that can be preloaded at any time.
// Latency: mem_done rises LATENCY+5 cycles after the request capture edge; the four words are read one per cycle.
// Backpressure: none; the requester holds mem_req_in until mem_done, and a request that stays high is served only once.
module imem_line_server #(
  parameter int LATENCY = 2,
  parameter int LINES   = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_req_in,
  input  logic [7:0]   in_addr,
  output logic [127:0] data_out,
  output logic         mem_done,
  input  logic         ld_en,
  input  logic [9:0]   ld_addr,
  input  logic [31:0]  ld_data
);

  localparam int WORDS = LINES * 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    DONE,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          line_q, line_d;
  logic [1:0]          beat_q, beat_d;
  logic                issued_q, issued_d;
  logic                rd_vld_q, rd_vld_d;
  logic [1:0]          rd_beat_q, rd_beat_d;
  logic [3:0][31:0]    line_buf_q, line_buf_d;
  logic [127:0]        data_out_q, data_out_d;

  logic                rd_en;
  logic [9:0]          rd_addr;
  logic [31:0]         mem_rdata;
  logic [31:0]         mem [WORDS];

  assign rd_addr  = {line_q, beat_q};
  assign data_out = data_out_q;
  assign mem_done = (state_q == DONE);

  // Backing store: preload writes land in any state and survive reset; a read that
  // collides with a preload write of the same word returns the freshly written data.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    if (rd_en) begin
      mem_rdata <= (ld_en && (ld_addr == rd_addr)) ? ld_data : mem[rd_addr];
    end
  end

  // Next-state logic: wait LATENCY cycles, issue four word reads, store each returning
  // word one cycle later, then publish the whole line at once on entry to DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    beat_d     = beat_q;
    issued_d   = issued_q;
    rd_vld_d   = 1'b0;
    rd_beat_d  = rd_beat_q;
    line_buf_d = line_buf_q;
    data_out_d = data_out_q;
    rd_en      = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d   = 2'd0;
        issued_d = 1'b0;
        if (mem_req_in) begin
          line_d = in_addr;
          cnt_d  = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = READ;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          state_d = READ;
        end
      end

      READ: begin
        // Issue side: one word address per cycle; the beat counter parks at 3 and is
        // only returned to 0 back in IDLE.
        if (!issued_q) begin
          rd_en     = 1'b1;
          rd_vld_d  = 1'b1;
          rd_beat_d = beat_q;
          if (beat_q == 2'd3) begin
            issued_d = 1'b1;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
        // Store side: the synchronous read returns the word one cycle after issue.
        if (rd_vld_q) begin
          line_buf_d[rd_beat_q] = mem_rdata;
          if (rd_beat_q == 2'd3) begin
            data_out_d = {mem_rdata, line_buf_q[2], line_buf_q[1], line_buf_q[0]};
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        state_d = HOLD;
      end

      HOLD: begin
        if (!mem_req_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction and clears the visible line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      line_q     <= 8'd0;
      beat_q     <= 2'd0;
      issued_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_beat_q  <= 2'd0;
      line_buf_q <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      issued_q   <= issued_d;
      rd_vld_q   <= rd_vld_d;
      rd_beat_q  <= rd_beat_d;
      line_buf_q <= line_buf_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_imem_line_server.sv
// Bench for imem_line_server: two instances (LATENCY 2 and 0) share all inputs.
// Expected lines and done cycles are queued at request time from a word-array model.
// A negedge monitor pops and compares on every mem_done and checks data_out holds in between.
module tb_imem_line_server;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_req_in;
  logic [7:0]   in_addr;
  logic         ld_en;
  logic [9:0]   ld_addr;
  logic [31:0]  ld_data;
  logic [127:0] dout_a, dout_b;
  logic         done_a, done_b;

  always #5 clk = ~clk;

  imem_line_server #(.LATENCY(LAT_A), .LINES(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .mem_req_in(mem_req_in), .in_addr(in_addr),
    .data_out(dout_a), .mem_done(done_a),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_line_server #(.LATENCY(LAT_B), .LINES(256)) dut_b (
    .clk(clk), .reset_n(reset_n), .mem_req_in(mem_req_in), .in_addr(in_addr),
    .data_out(dout_b), .mem_done(done_b),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct {
    logic [127:0] line;
    int           due;
  } exp_t;

  exp_t         q_a[$];
  exp_t         q_b[$];
  int           errors = 0;
  int           checks = 0;
  int           pushed_a = 0, pushed_b = 0, seen_a = 0, seen_b = 0;
  int           cyc = 0;
  logic [127:0] last_a = '0;
  logic [127:0] last_b = '0;
  logic [31:0]  model_mem [1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word w of a line is sampled lat+1+w edges after capture; a preload seen at or
  // before that edge wins, otherwise the stored value at request time is returned.
  function automatic logic [127:0] exp_line(input int lat, input logic [7:0] a, input int ld_rel,
                                            input logic [9:0] la, input logic [31:0] ld);
    logic [127:0] r;
    logic [31:0]  v;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      v = model_mem[{a, 2'(w)}];
      if (ld_rel > 0 && la == {a, 2'(w)} && ld_rel <= lat + 1 + w) v = ld;
      r[w*32 +: 32] = v;
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation, and data_out
  // must otherwise hold the last completed line (zero after reset).
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_a = '0;
      last_b = '0;
    end
    if (done_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_a_unexpected: got mem_done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q_a.pop_front();
        seen_a++;
        chk("line_a", dout_a, e.line);
        chk("latency_a", cyc, e.due);
        last_a = e.line;
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_b_unexpected: got mem_done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q_b.pop_front();
        seen_b++;
        chk("line_b", dout_b, e.line);
        chk("latency_b", cyc, e.due);
        last_b = e.line;
      end
    end
    chk("hold_a", dout_a, last_a);
    chk("hold_b", dout_b, last_b);
  end

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    model_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One request: optional in_addr change after capture, optional preload at edge
  // capture+ld_rel, optional early drop at edge capture+drop_rel, then hold cycles.
  task automatic run_txn(input logic [7:0] addr, input bit chg, input int ld_rel,
                         input logic [9:0] ld_a, input logic [31:0] ld_d,
                         input int drop_rel, input int hold);
    int   cap;
    exp_t e;
    @(negedge clk);
    in_addr = addr; mem_req_in = 1'b1; ld_en = 1'b0;
    cap = cyc + 1;
    e.line = exp_line(LAT_A, addr, ld_rel, ld_a, ld_d); e.due = cap + LAT_A + 5;
    q_a.push_back(e); pushed_a++;
    e.line = exp_line(LAT_B, addr, ld_rel, ld_a, ld_d); e.due = cap + LAT_B + 5;
    q_b.push_back(e); pushed_b++;
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      ld_en = 1'b0;
      if (rel == 1) in_addr = chg ? 8'(addr + 8'd1) : 8'($urandom);
      if (rel == ld_rel) begin
        ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
      end
      if (rel == drop_rel) mem_req_in = 1'b0;
    end
    ld_en = 1'b0;
    if (ld_rel > 0) model_mem[ld_a] = ld_d;
    if (mem_req_in) begin
      repeat (hold) @(negedge clk);
      mem_req_in = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  // Request aborted by reset while the LATENCY=2 instance reads beat 2.
  task automatic run_abort(input logic [7:0] addr);
    @(negedge clk);
    in_addr = addr; mem_req_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      in_addr = 8'($urandom);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    mem_req_in = 1'b0;
    #1;
    chk("abort_dout_a", dout_a, 128'd0);
    chk("abort_done_a", {127'd0, done_a}, 128'd0);
    chk("abort_dout_b", dout_b, 128'd0);
    chk("abort_done_b", {127'd0, done_b}, 128'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    int         ld_rel, drop_rel;
    logic [9:0] la;
    reset_n = 1'b0; mem_req_in = 1'b0; in_addr = 8'd0;
    ld_en = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout_a", dout_a, 128'd0);
    chk("reset_done_a", {127'd0, done_a}, 128'd0);
    chk("reset_dout_b", dout_b, 128'd0);
    chk("reset_done_b", {127'd0, done_b}, 128'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    for (int i = 0; i < 1024; i++) load_word(10'(i), $urandom);
    load_word({8'h05, 2'd0}, 32'h11111111);
    load_word({8'h05, 2'd1}, 32'h22222222);
    load_word({8'h05, 2'd2}, 32'h33333333);
    load_word({8'h05, 2'd3}, 32'h44444444);
    for (int w = 0; w < 4; w++) load_word({8'hFF, 2'(w)}, 32'hA5A50000 | 32'(w));

    // Basic line, request held 20 cycles past done.
    run_txn(8'h05, 1'b0, 0, 10'd0, 32'd0, 0, 20);
    chk("basic_line5", dout_a, 128'h44444444_33333333_22222222_11111111);
    // in_addr moves to 0x06 right after capture.
    run_txn(8'h05, 1'b1, 0, 10'd0, 32'd0, 0, 0);
    chk("addr_change_line5", dout_a, 128'h44444444_33333333_22222222_11111111);
    // Preload of word 3 while beat 1 is being read.
    run_txn(8'h05, 1'b0, 4, {8'h05, 2'd3}, 32'hDEADBEEF, 0, 0);
    chk("midread_word3", {96'd0, dout_a[127:96]}, 128'hDEADBEEF);
    // Reset mid-read, then the top line including word 1023.
    run_abort(8'h05);
    run_txn(8'hFF, 1'b0, 0, 10'd0, 32'd0, 0, 3);
    chk("line255", dout_a, 128'hA5A50003_A5A50002_A5A50001_A5A50000);
    // Early drop of the request.
    run_txn(8'h05, 1'b0, 0, 10'd0, 32'd0, 3, 0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: a = 8'h05;
        1: a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      ld_rel = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
      la = ($urandom_range(0, 3) != 0) ? {a, 2'($urandom_range(0, 3))} : 10'($urandom);
      drop_rel = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      if ($urandom_range(0, 2) == 0) load_word(10'($urandom), $urandom);
      run_txn(a, 1'b0, ld_rel, la, $urandom, drop_rel, int'($urandom_range(0, 4)));
    end

    repeat (5) @(negedge clk);
    chk("done_count_a", 128'(seen_a), 128'(pushed_a));
    chk("done_count_b", 128'(seen_b), 128'(pushed_b));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
